// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multi-cycle MIPS control sequencer in front of the ALU datapath.
// Takes one instruction per inst_valid/inst_ready handshake. Steps through
// DECODE, EXEC, optional MEM and WB. Produces the ALU function code, the operand
// selects and the regfile/memory/PC strobes.
// Ports:
//   clk, rst_b                 clock and async active-low reset
//   inst_valid/inst_ready/inst instruction handshake (ready only in IDLE)
//   alu_zero                   ALU condition flag, sampled at the end of EXEC
//   mem_ready                  data memory access complete
//   alu_func, alu_src_imm,     decoded controls; registered out of DECODE and
//   imm_zext, reg_dst_rd, link   held until the sequencer returns to IDLE
//   reg_write, mem_read,       state-qualified strobes
//   mem_write, pc_write, done
//   illegal, mem_err, halt     sticky status; each clears only on reset
module alu_ctrl_fsm #(
  parameter int SUPPORT_MULDIV = 1,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic [5:0]  alu_func,
  output logic        alu_src_imm,
  output logic        imm_zext,
  output logic        reg_dst_rd,
  output logic        reg_write,
  output logic        link,
  output logic        mem_read,
  output logic        mem_write,
  output logic        pc_write,
  output logic        done,
  output logic        illegal,
  output logic        mem_err,
  output logic        halt
);

  // state   | meaning
  // S_IDLE  | waiting for an instruction; ready unless a sticky flag is set
  // S_DECODE| decode latched instruction; register controls or flag illegal
  // S_EXEC  | ALU operates; alu_zero captured for branches
  // S_MEM   | load/store access; bounded wait for mem_ready
  // S_WB    | retire: done, register write, PC update
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  localparam int CW = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;

  state_t state, next_state;

  logic [5:0]    op_q, funct_q;
  logic [4:0]    rt_q;
  logic          br_q, jmp_q, mem_q, ld_q, wr_q, sys_q, taken_q;
  logic [CW-1:0] cnt;
  logic          mem_timeout;

  logic [5:0] d_func;
  logic       d_imm, d_zext, d_rd, d_link, d_br, d_jmp, d_mem, d_ld, d_wr, d_sys, d_illegal;

  // rs, rd, shamt and imm16 are consumed by the datapath, not by the sequencer
  logic unused_inst;
  assign unused_inst = ^{inst[25:21], inst[15:6]};

  always_comb begin
    d_func = 6'b000000; d_imm = 1'b0; d_zext = 1'b0; d_rd = 1'b0; d_link = 1'b0;
    d_br = 1'b0; d_jmp = 1'b0; d_mem = 1'b0; d_ld = 1'b0; d_wr = 1'b0; d_sys = 1'b0;
    d_illegal = 1'b0;
    case (op_q)
      6'b000000: begin
        d_func = funct_q;
        d_rd   = 1'b1;
        d_wr   = 1'b1;
        case (funct_q)
          6'b100110, 6'b000000, 6'b000100, 6'b000010, 6'b100010, 6'b000110, 6'b101010,
          6'b100011, 6'b100101, 6'b100111, 6'b100001, 6'b100000, 6'b100100, 6'b000011: ;
          6'b011000, 6'b011010: d_illegal = (SUPPORT_MULDIV == 0);
          6'b001100: begin
            d_sys  = 1'b1;
            d_func = 6'b000000;
            d_rd   = 1'b0;
            d_wr   = 1'b0;
          end
          default: d_illegal = 1'b1;
        endcase
      end
      6'b001001: begin d_func = 6'b100001; d_imm = 1'b1; d_wr = 1'b1; end
      6'b100011: begin d_func = 6'b100001; d_imm = 1'b1; d_wr = 1'b1; d_mem = 1'b1; d_ld = 1'b1; end
      6'b101011: begin d_func = 6'b100001; d_imm = 1'b1; d_mem = 1'b1; end
      6'b001100: begin d_func = 6'b100100; d_imm = 1'b1; d_zext = 1'b1; d_wr = 1'b1; end
      6'b001101: begin d_func = 6'b100101; d_imm = 1'b1; d_zext = 1'b1; d_wr = 1'b1; end
      6'b001110: begin d_func = 6'b100110; d_imm = 1'b1; d_zext = 1'b1; d_wr = 1'b1; end
      6'b001010: begin d_func = 6'b101010; d_imm = 1'b1; d_wr = 1'b1; end
      6'b001111: begin d_func = 6'b111101; d_imm = 1'b1; d_wr = 1'b1; end
      6'b000100: begin d_func = 6'b111000; d_br = 1'b1; end
      6'b000101: begin d_func = 6'b111001; d_br = 1'b1; end
      6'b000110: begin d_func = 6'b111010; d_br = 1'b1; end
      6'b000111: begin d_func = 6'b111011; d_br = 1'b1; end
      6'b000001: begin
        if (rt_q == 5'b00001) begin
          d_func = 6'b111100;
          d_br   = 1'b1;
        end else begin
          d_illegal = 1'b1;
        end
      end
      6'b000010: d_jmp = 1'b1;
      6'b000011: begin d_jmp = 1'b1; d_link = 1'b1; d_wr = 1'b1; end
      default:   d_illegal = 1'b1;
    endcase
  end

  // mem_ready wins over the limit so a completion on the last allowed cycle is a success
  assign mem_timeout = (state == S_MEM) && !mem_ready && (cnt == CW'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    inst_ready = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        inst_ready = !(halt || illegal || mem_err);
        if (inst_valid && inst_ready) next_state = S_DECODE;
      end
      S_DECODE: next_state = d_illegal ? S_IDLE : S_EXEC;
      S_EXEC:   next_state = mem_q ? S_MEM : S_WB;
      S_MEM: begin
        mem_read  = ld_q;
        mem_write = !ld_q;
        if (mem_ready)        next_state = S_WB;
        else if (mem_timeout) next_state = S_IDLE;
      end
      S_WB: begin
        done       = 1'b1;
        reg_write  = wr_q;
        pc_write   = jmp_q || (br_q && taken_q);
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      op_q <= '0; funct_q <= '0; rt_q <= '0;
      alu_func <= '0; alu_src_imm <= 1'b0; imm_zext <= 1'b0; reg_dst_rd <= 1'b0; link <= 1'b0;
      br_q <= 1'b0; jmp_q <= 1'b0; mem_q <= 1'b0; ld_q <= 1'b0; wr_q <= 1'b0; sys_q <= 1'b0;
      taken_q <= 1'b0;
      cnt <= '0;
      illegal <= 1'b0; mem_err <= 1'b0; halt <= 1'b0;
    end else begin
      if (state == S_IDLE && inst_valid && inst_ready) begin
        op_q    <= inst[31:26];
        rt_q    <= inst[20:16];
        funct_q <= inst[5:0];
      end
      if (state == S_DECODE && !d_illegal) begin
        alu_func <= d_func; alu_src_imm <= d_imm; imm_zext <= d_zext;
        reg_dst_rd <= d_rd; link <= d_link;
        br_q <= d_br; jmp_q <= d_jmp; mem_q <= d_mem; ld_q <= d_ld; wr_q <= d_wr; sys_q <= d_sys;
      end else if (next_state == S_IDLE) begin
        alu_func <= '0; alu_src_imm <= 1'b0; imm_zext <= 1'b0; reg_dst_rd <= 1'b0; link <= 1'b0;
        br_q <= 1'b0; jmp_q <= 1'b0; mem_q <= 1'b0; ld_q <= 1'b0; wr_q <= 1'b0; sys_q <= 1'b0;
      end
      if (state == S_EXEC) taken_q <= alu_zero;
      if (state == S_MEM) cnt <= cnt + CW'(1);
      else                cnt <= '0;
      if (state == S_DECODE && d_illegal) illegal <= 1'b1;
      if (mem_timeout)                    mem_err <= 1'b1;
      if (state == S_WB && sys_q)         halt    <= 1'b1;
    end
  end

endmodule
